spart_driver: RTL and testbench
===============================

SPART_DRIVER -- requirements
Module: spart_driver

Interface
REQ-001: clk  input  1  system clock; all state changes on rising edge.
REQ-002: rst  input  1  asynchronous, active-high reset.
REQ-003: br_cfg  input  2  baud select: 00=9600, 01=19200, 10=38400, 11=76800.
REQ-004: rda  input  1  SPART receive data available.
REQ-005: tbr  input  1  SPART transmit buffer ready.
REQ-006: iocs  output  1  SPART chip select; high only during a bus-access cycle.
REQ-007: iorw  output  1  1=read from SPART, 0=write to SPART.
REQ-008: ioaddr  output  2  register select: 00=TX/RX buffer, 01=status, 10=DB low, 11=DB high.
REQ-009: databus  inout  8  shared data bus; driven only on write cycles, else high-Z.
REQ-010: echo_cnt  output  8  count of bytes echoed since reset.
REQ-011: The block shall use one clock, clk; reset rst is asynchronous and active-high.

Function
REQ-012: The block shall implement states CFG_LO, CFG_HI, IDLE, RD, WAIT_TBR, WR.
REQ-013: Each of CFG_LO, CFG_HI, RD and WR shall last exactly one clk cycle.
REQ-014: Divisor table, clk cycles per bit at 50 MHz: 00->16'h1458, 01->16'h0A2C, 10->16'h0516, 11->16'h028B.
REQ-015: CFG_LO shall drive iocs=1, iorw=0, ioaddr=10, databus=divisor[7:0], latch br_cfg into cfg_q, and go to CFG_HI.
REQ-016: CFG_HI shall drive iocs=1, iorw=0, ioaddr=11, databus=divisor[15:8] of cfg_q, and go to IDLE.
REQ-017: IDLE shall drive iocs=0, iorw=1, ioaddr=00, databus Z.
REQ-018: IDLE priority: if br_cfg!=cfg_q, go to CFG_LO; else if rda=1, go to RD; else stay in IDLE.
REQ-019: RD shall drive iocs=1, iorw=1, ioaddr=00, databus Z, capture databus into rx_byte at the closing edge, and go to WAIT_TBR.
REQ-020: WAIT_TBR shall drive iocs=0, iorw=1, ioaddr=00; go to WR when tbr=1, else stay.
REQ-021: WR shall drive iocs=1, iorw=0, ioaddr=00, databus=rx_byte, increment echo_cnt, and go to IDLE.
REQ-022: echo_cnt shall be 8 bits and wrap from 8'hFF to 8'h00.
REQ-023: A br_cfg change during RD, WAIT_TBR or WR shall not abort the echo; reconfiguration shall occur on the first IDLE cycle after WR.
REQ-024: If br_cfg changes again before CFG_LO, CFG_LO shall latch the value present in the CFG_LO cycle.
REQ-025: If rda and a br_cfg change occur in the same IDLE cycle, reconfiguration shall win; rda is serviced after CFG_HI.
REQ-026: databus shall be high-Z whenever iorw=1 or iocs=0; the block shall never drive and read in the same cycle.
REQ-027: WAIT_TBR shall have no timeout; the block waits indefinitely for tbr.
REQ-028: Outputs iocs, iorw, ioaddr and the databus enable shall be registered or decoded from registered state only, with no combinational path from rda/tbr.

Reset
REQ-029: While rst=1, state shall be CFG_LO-pending with iocs=0, iorw=1, ioaddr=00, databus Z, echo_cnt=0, rx_byte=0, cfg_q=00.
REQ-030: Reset assertion mid-operation, including during WR, shall release databus to Z immediately, without waiting for clk.
REQ-031: The first cycle after rst deasserts shall be CFG_LO, so the divisor is always written after reset.

Verification
REQ-032: Reset release with br_cfg=00 -> cycle 1: iocs=1, iorw=0, ioaddr=10, databus=8'h58; cycle 2: ioaddr=11, databus=8'h14; cycle 3: iocs=0.
REQ-033: In IDLE, pulse rda while the SPART model presents 8'hA5, with tbr=1 -> RD cycle with iorw=1, then WR cycle with databus=8'hA5 and ioaddr=00; echo_cnt becomes 1.
REQ-034: Hold tbr=0 for 20 cycles after RD -> block stays in WAIT_TBR with iocs=0; tbr=1 -> WR on the next cycle.
REQ-035: Change br_cfg 00->11 during WAIT_TBR -> WR completes, then CFG_LO writes 8'h8B and CFG_HI writes 8'h02.
REQ-036: Echo 256 bytes -> echo_cnt wraps to 8'h00.
REQ-037: Assert rst during WR -> databus goes Z asynchronously and echo_cnt=0; after release, the CFG_LO/CFG_HI sequence repeats.

Source files
------------

// File: rtl/spart_driver_if.sv
// Handshake and register-select signals between the echo driver and the SPART.
// The shared data bus stays a plain inout on the driver so tristate resolution remains at module level.
interface spart_driver_if;
    logic       rda;
    logic       tbr;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;

    modport master (
        input  rda,
        input  tbr,
        output iocs,
        output iorw,
        output ioaddr
    );

    modport slave (
        output rda,
        output tbr,
        input  iocs,
        input  iorw,
        input  ioaddr
    );
endinterface

// File: rtl/spart_driver.sv
// SPART echo driver: programs the baud divisor, then echoes every received byte back out.
// Reconfigures whenever br_cfg changes while idle, and counts echoed bytes.
module spart_driver (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    br_cfg,
    spart_driver_if.master bus,
    inout  wire  [7:0]    databus,
    output logic [7:0]    echo_cnt
);

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        RD,
        WAIT_TBR,
        WR
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       armed;
    logic [1:0] cfg_q;
    logic [7:0] rx_byte;
    logic [15:0] div_now;
    logic [15:0] div_q;
    logic       drive_en;
    logic [7:0] dout;

    function automatic logic [15:0] divisor(input logic [1:0] sel);
        logic [15:0] d;
        case (sel)
            2'b00:   d = 16'h1458;
            2'b01:   d = 16'h0A2C;
            2'b10:   d = 16'h0516;
            default: d = 16'h028B;
        endcase
        return d;
    endfunction

    assign div_now = divisor(br_cfg);
    assign div_q   = divisor(cfg_q);

    // armed holds the bus quiet for the reset-release cycle so CFG_LO is the first real cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CFG_LO;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (armed) begin
                state <= state_next;
            end
        end
    end

    // Bus controls depend only on registered state, never on rda/tbr.
    always_comb begin
        state_next = state;
        bus.iocs   = 1'b0;
        bus.iorw   = 1'b1;
        bus.ioaddr = 2'b00;
        drive_en   = 1'b0;
        dout       = '0;
        if (armed) begin
            case (state)
                CFG_LO: begin
                    bus.iocs   = 1'b1;
                    bus.iorw   = 1'b0;
                    bus.ioaddr = 2'b10;
                    drive_en   = 1'b1;
                    dout       = div_now[7:0];
                    state_next = CFG_HI;
                end
                CFG_HI: begin
                    bus.iocs   = 1'b1;
                    bus.iorw   = 1'b0;
                    bus.ioaddr = 2'b11;
                    drive_en   = 1'b1;
                    dout       = div_q[15:8];
                    state_next = IDLE;
                end
                IDLE: begin
                    if (br_cfg != cfg_q) begin
                        state_next = CFG_LO;
                    end else if (bus.rda) begin
                        state_next = RD;
                    end
                end
                RD: begin
                    bus.iocs   = 1'b1;
                    state_next = WAIT_TBR;
                end
                WAIT_TBR: begin
                    if (bus.tbr) begin
                        state_next = WR;
                    end
                end
                WR: begin
                    bus.iocs   = 1'b1;
                    bus.iorw   = 1'b0;
                    drive_en   = 1'b1;
                    dout       = rx_byte;
                    state_next = IDLE;
                end
                default: begin
                    state_next = CFG_LO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q    <= '0;
            rx_byte  <= '0;
            echo_cnt <= '0;
        end else if (armed) begin
            case (state)
                CFG_LO:  cfg_q    <= br_cfg;
                RD:      rx_byte  <= databus;
                WR:      echo_cnt <= echo_cnt + 8'd1;
                default: ;
            endcase
        end
    end

    assign databus = drive_en ? dout : 'z;

endmodule

// File: tb/tb_spart_driver.sv
// Self-checking bench for spart_driver: directed scenarios plus random traffic
// compared every cycle against a behavioural model with a divisor formula and an echo queue.
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] br_cfg = 2'b00;
    logic [7:0] spart_data = 8'h3C;
    logic       tb_drive = 1'b1;
    logic       chk_en = 1'b0;
    wire  [7:0] databus;
    logic [7:0] echo_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;

    spart_driver_if bus ();

    spart_driver dut (
        .clk      (clk),
        .rst      (rst),
        .br_cfg   (br_cfg),
        .bus      (bus),
        .databus  (databus),
        .echo_cnt (echo_cnt)
    );

    // SPART side presents read data whenever the driver is not expected to drive.
    assign databus = tb_drive ? spart_data : 8'hzz;

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef enum {M_PEND, M_LO, M_HI, M_IDLE, M_RD, M_WAIT, M_WR} mstate_t;
    mstate_t     m_st = M_PEND;
    logic [1:0]  m_cfg = 2'b00;
    int unsigned m_cnt = 0;
    logic [7:0]  rxq[$];

    function automatic logic [15:0] ref_div(input logic [1:0] sel);
        int unsigned baud;
        baud = 9600 << sel;
        return 16'(50_000_000 / baud);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st  = M_PEND;
            m_cfg = 2'b00;
            m_cnt = 0;
            rxq.delete();
        end else begin
            case (m_st)
                M_PEND: m_st = M_LO;
                M_LO:   begin m_cfg = br_cfg; m_st = M_HI; end
                M_HI:   m_st = M_IDLE;
                M_IDLE: begin
                    if (br_cfg != m_cfg) m_st = M_LO;
                    else if (bus.rda)    m_st = M_RD;
                end
                M_RD:   begin rxq.push_back(spart_data); m_st = M_WAIT; end
                M_WAIT: if (bus.tbr) m_st = M_WR;
                M_WR:   begin
                    if (rxq.size() > 0) void'(rxq.pop_front());
                    m_cnt = (m_cnt + 1) % 256;
                    m_st  = M_IDLE;
                end
                default: m_st = M_PEND;
            endcase
        end
        tb_drive = !(m_st == M_LO || m_st == M_HI || m_st == M_WR);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        logic [15:0] d;
        logic        e_iocs;
        logic        e_iorw;
        logic [1:0]  e_addr;
        logic [7:0]  e_data;
        logic [19:0] e_vec;
        logic [19:0] a_vec;
        if (chk_en) begin
            e_iocs = 1'b0;
            e_iorw = 1'b1;
            e_addr = 2'b00;
            e_data = spart_data;
            case (m_st)
                M_LO: begin
                    d = ref_div(br_cfg);
                    e_iocs = 1'b1; e_iorw = 1'b0; e_addr = 2'b10; e_data = d[7:0];
                end
                M_HI: begin
                    d = ref_div(m_cfg);
                    e_iocs = 1'b1; e_iorw = 1'b0; e_addr = 2'b11; e_data = d[15:8];
                end
                M_RD: e_iocs = 1'b1;
                M_WR: begin
                    e_iocs = 1'b1; e_iorw = 1'b0;
                    e_data = (rxq.size() > 0) ? rxq[0] : 8'h00;
                end
                default: ;
            endcase
            e_vec = {e_iocs, e_iorw, e_addr, e_data, 8'(m_cnt)};
            a_vec = {bus.iocs, bus.iorw, bus.ioaddr, databus, echo_cnt};
            checks++;
            if (a_vec !== e_vec) begin
                errors++;
                $display("FAIL cycle_model t=%0t {iocs,iorw,ioaddr,databus,echo_cnt} actual=%h required=%h",
                         $time, a_vec, e_vec);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_wr();
        return bus.iocs && !bus.iorw && bus.ioaddr == 2'b00;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int unsigned wr_seen;
        logic        found;
        bus.rda = 1'b0;
        bus.tbr = 1'b0;

        // Reset state and divisor programming after release (br_cfg=00).
        repeat (3) step();
        chk_en = 1'b1;
        chk("rst_iocs", 32'(bus.iocs), 32'd0);
        chk("rst_iorw", 32'(bus.iorw), 32'd1);
        chk("rst_cnt", 32'(echo_cnt), 32'd0);
        chk("rst_bus_z", 32'(databus), 32'h3C);
        rst = 1'b0;
        step();
        chk("cfg_lo_addr", {bus.iocs, bus.iorw, bus.ioaddr}, 32'b1010);
        chk("cfg_lo_data", 32'(databus), 32'h58);
        step();
        chk("cfg_hi_addr", 32'(bus.ioaddr), 32'b11);
        chk("cfg_hi_data", 32'(databus), 32'h14);
        step();
        chk("cfg_done_iocs", 32'(bus.iocs), 32'd0);

        // Single echo of 8'hA5 with tbr already high.
        spart_data = 8'hA5; bus.rda = 1'b1; bus.tbr = 1'b1;
        step();
        chk("rd_cycle", {bus.iocs, bus.iorw, bus.ioaddr}, 32'b1100);
        bus.rda = 1'b0;
        step();
        step();
        chk("wr_cycle", {bus.iocs, bus.iorw, bus.ioaddr}, 32'b1000);
        chk("wr_data", 32'(databus), 32'hA5);
        step();
        chk("echo_one", 32'(echo_cnt), 32'd1);

        // tbr held low for 20 cycles after RD.
        spart_data = 8'h5A; bus.rda = 1'b1; bus.tbr = 1'b0;
        step();
        bus.rda = 1'b0;
        for (int unsigned i = 0; i < 20; i++) begin
            step();
            chk("wait_tbr_iocs", 32'(bus.iocs), 32'd0);
        end
        bus.tbr = 1'b1;
        step();
        chk("wait_release_wr", {bus.iocs, bus.iorw, bus.ioaddr}, 32'b1000);
        chk("wait_release_data", 32'(databus), 32'h5A);
        step();

        // br_cfg change during WAIT_TBR completes the echo, then reprograms.
        spart_data = 8'hC3; bus.rda = 1'b1; bus.tbr = 1'b0;
        step();
        bus.rda = 1'b0;
        step();
        br_cfg = 2'b11;
        step();
        bus.tbr = 1'b1;
        step();
        chk("late_cfg_wr_data", 32'(databus), 32'hC3);
        step();
        chk("late_cfg_idle", 32'(bus.iocs), 32'd0);
        step();
        chk("recfg_lo", {bus.ioaddr, databus}, {22'd0, 2'b10, 8'h8B});
        step();
        chk("recfg_hi", {bus.ioaddr, databus}, {22'd0, 2'b11, 8'h02});
        step();

        // Random traffic, model compare every cycle.
        for (int unsigned i = 0; i < 3000; i++) begin
            bus.rda    = ($urandom_range(0, 2) == 0);
            bus.tbr    = ($urandom_range(0, 3) != 0);
            spart_data = 8'($urandom);
            if ($urandom_range(0, 47) == 0) br_cfg = 2'($urandom);
            step();
        end

        // Echo 256 bytes from a fresh reset: counter wraps to zero.
        bus.rda = 1'b0;
        rst = 1'b1;
        br_cfg = 2'b01;
        step();
        step();
        rst = 1'b0;
        bus.rda = 1'b1; bus.tbr = 1'b1;
        wr_seen = 0;
        for (int unsigned i = 0; i < 2000 && wr_seen < 256; i++) begin
            spart_data = 8'($urandom);
            step();
            if (in_wr()) wr_seen++;
        end
        chk("wrap_wr_count", wr_seen, 32'd256);
        chk("wrap_cnt_ff", 32'(echo_cnt), 32'hFF);
        step();
        chk("wrap_cnt_00", 32'(echo_cnt), 32'h00);

        // Reset asserted in the middle of a WR cycle.
        found = 1'b0;
        for (int unsigned i = 0; i < 20 && !found; i++) begin
            step();
            found = in_wr();
        end
        chk("wr_found", 32'(found), 32'd1);
        spart_data = 8'h96;
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_bus", 32'(databus), 32'h96);
        chk("async_rst_cnt", 32'(echo_cnt), 32'd0);
        chk("async_rst_iocs", 32'(bus.iocs), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("rerst_lo", {bus.iocs, bus.iorw, bus.ioaddr, databus}, {20'd0, 4'b1010, 8'h2C});
        step();
        chk("rerst_hi", {bus.ioaddr, databus}, {22'd0, 2'b11, 8'h0A});

        bus.rda = 1'b0;
        repeat (6) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
